// File: rtl/ftdi_uart.sv
// 8N1 byte transmitter toward the FTDI USB-serial bridge.
// Serialises one byte per accepted initialize and raises a sticky done when the stop bit ends.
module ftdi_uart #(
  parameter int FREQUENCY = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       initialize,
  output logic       ready,
  output logic       done,
  output logic       baud_tick,
  output logic [1:0] state_test,
  output logic       FTDI_RX,
  input  logic       FTDI_TX,
  input  logic       FTDI_DTR,
  output logic       FTDI_CTS
);

  localparam int DIV   = FREQUENCY / BAUD_RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx, tx_n;
  logic             done_r, done_n;
  logic             tick_r, tick_n;
  logic             bit_end;

  // The receive line and DTR are deliberately not used by this transmit-only block.
  logic unused_inputs;
  assign unused_inputs = FTDI_TX ^ FTDI_DTR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx     <= 1'b1;
      done_r <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      tx     <= tx_n;
      done_r <= done_n;
      tick_r <= tick_n;
    end
  end

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    done_n  = done_r;
    tick_n  = 1'b0;
    tx_n    = 1'b1;
    if (state == IDLE) begin
      cnt_n = '0;
      if (initialize) begin
        shreg_n = data;
        state_n = START;
        done_n  = 1'b0;
      end
    end else if (bit_end) begin
      cnt_n  = '0;
      tick_n = 1'b1;
      case (state)
        START: begin
          state_n = DATA;
          idx_n   = '0;
        end
        DATA: begin
          shreg_n = shreg >> 1;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      endcase
    end else begin
      cnt_n = cnt + 1'b1;
    end
    // Line level is computed from the next state so FTDI_RX comes straight from a flop.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign ready      = (state == IDLE);
  assign done       = done_r;
  assign baud_tick  = tick_r;
  assign state_test = state;
  assign FTDI_RX    = tx;
  assign FTDI_CTS   = 1'b0;

endmodule

// File: tb/tb_ftdi_uart.sv
// Directed bench for ftdi_uart: a DIV=4 instance for frame-level checks and a default-parameter
// instance for real bit timing.
module tb_ftdi_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       initialize;
  logic       ftdi_tx;
  logic       ftdi_dtr;
  logic       ready, done, baud_tick, ftdi_rx, ftdi_cts;
  logic [1:0] state_test;

  logic [7:0] data2;
  logic       init2;
  logic       ready2, done2, tick2, rx2, cts2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ftdi_uart #(.FREQUENCY(40), .BAUD_RATE(10)) dut (
    .clk(clk), .reset(reset), .data(data), .initialize(initialize),
    .ready(ready), .done(done), .baud_tick(baud_tick), .state_test(state_test),
    .FTDI_RX(ftdi_rx), .FTDI_TX(ftdi_tx), .FTDI_DTR(ftdi_dtr), .FTDI_CTS(ftdi_cts)
  );

  ftdi_uart dut_def (
    .clk(clk), .reset(reset), .data(data2), .initialize(init2),
    .ready(ready2), .done(done2), .baud_tick(tick2), .state_test(state2),
    .FTDI_RX(rx2), .FTDI_TX(ftdi_tx), .FTDI_DTR(ftdi_dtr), .FTDI_CTS(cts2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ftdi_tx  = 1'($urandom);
    ftdi_dtr = 1'($urandom);
  endtask

  // Sends one DIV=4 frame and checks every cycle of it; optionally pokes initialize mid-DATA.
  task automatic run_frame(input logic [7:0] d, input bit busy_poke);
    logic [9:0] bits;
    int ticks;
    logic [1:0] exp_state;
    bits  = {1'b1, d, 1'b0};
    ticks = 0;
    data = d;
    initialize = 1'b1;
    step();
    initialize = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_state = (i < 4) ? 2'd1 : ((i < 36) ? 2'd2 : 2'd3);
      chk("frame_rx", 32'(ftdi_rx), 32'(bits[i/4]));
      chk("frame_state", 32'(state_test), 32'(exp_state));
      chk("frame_ready", 32'(ready), 32'd0);
      chk("frame_done", 32'(done), 32'd0);
      if (baud_tick) ticks++;
      if (busy_poke && i == 18) begin
        data = 8'hFF;
        initialize = 1'b1;
      end else begin
        initialize = 1'b0;
      end
      step();
    end
    if (baud_tick) ticks++;
    chk("end_ticks", 32'(ticks), 32'd10);
    chk("end_ready", 32'(ready), 32'd1);
    chk("end_done", 32'(done), 32'd1);
    chk("end_rx", 32'(ftdi_rx), 32'd1);
    chk("end_state", 32'(state_test), 32'd0);
  endtask

  initial begin
    logic [9:0] bits2;
    int bad;
    reset = 1'b1; data = 8'h00; initialize = 1'b0; ftdi_tx = 1'b1; ftdi_dtr = 1'b0;
    data2 = 8'h00; init2 = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_rx", 32'(ftdi_rx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(state_test), 32'd0);
    chk("rst_cts", 32'(ftdi_cts), 32'd0);
    chk("rst_tick", 32'(baud_tick), 32'd0);
    reset = 1'b0;
    step(); step();
    chk("idle_tick", 32'(baud_tick), 32'd0);
    chk("idle_rx", 32'(ftdi_rx), 32'd1);

    // Basic frame and busy-ignore frame
    run_frame(8'hA5, 1'b0);
    step();
    run_frame(8'h00, 1'b1);
    step(); step();
    chk("done_sticky", 32'(done), 32'd1);

    // Reset during DATA bit 3
    data = 8'h5A; initialize = 1'b1;
    step();
    initialize = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("mid_state", 32'(state_test), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rx", 32'(ftdi_rx), 32'd1);
    chk("abort_state", 32'(state_test), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (baud_tick !== 1'b0 || ftdi_rx !== 1'b1) bad++;
      step();
    end
    chk("abort_quiet", 32'(bad), 32'd0);

    // Reset wins over initialize
    reset = 1'b1; initialize = 1'b1; data = 8'h11;
    step();
    reset = 1'b0; initialize = 1'b0;
    chk("rst_init_state", 32'(state_test), 32'd0);
    chk("rst_init_ready", 32'(ready), 32'd1);
    step();

    // Back-to-back: second accept on the first ready cycle
    run_frame(8'h3C, 1'b0);
    run_frame(8'hC3, 1'b0);

    // Default parameters: every bit lasts 5208 cycles
    bits2 = {1'b1, 8'h96, 1'b0};
    data2 = 8'h96; init2 = 1'b1;
    step();
    init2 = 1'b0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 5208; c++) begin
        if (rx2 !== bits2[b]) bad++;
        if (b == 9 && c == 5207 && ready2 !== 1'b0) bad++;
        step();
      end
      chk($sformatf("def_bit%0d", b), 32'(bad), 32'd0);
    end
    chk("def_ready", 32'(ready2), 32'd1);
    chk("def_done", 32'(done2), 32'd1);
    chk("def_rx", 32'(rx2), 32'd1);
    chk("def_cts", 32'(cts2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
